sm4_host_ctrl: RTL
==================

// Module: sm4_host_ctrl
// PURPOSE
//   Initiator-side sequencer for the SM4 core top: drives its key-load, enable and block-valid pins.
//   Converts upstream key/block valid-ready streams into core pin sequences; collects core results.
//   Buffers results in a FIFO with downstream backpressure. The core itself cannot stall, so the
//   block issues new data only against free FIFO credit.
// PARAMETERS
//   FIFO_DEPTH  4  result FIFO entries; also the max in-flight blocks (power of 2, >=2)
//   CNT_W       3  width of credit/occupancy counters = log2(FIFO_DEPTH)+1
// PORTS
//   clk                 in   1    single clock, rising edge
//   reset_n             in   1    synchronous, active-low reset
//   key_valid_in        in   1    upstream key request valid
//   key_in              in   128  user key
//   key_dec_in          in   1    0=encrypt, 1=decrypt; captured with key
//   key_ready_out       out  1    key request accepted this cycle when high with key_valid_in
//   blk_valid_in        in   1    upstream data block valid
//   blk_data_in         in   128  plaintext/ciphertext block
//   blk_ready_out       out  1    block accepted when high with blk_valid_in
//   res_valid_out       out  1    result FIFO head valid
//   res_data_out        out  128  result FIFO head data
//   res_ready_in        in   1    downstream pops head when high with res_valid_out
//   sm4_enable_out      out  1    to core sm4_enable_in
//   encdec_enable_out   out  1    to core encdec_enable_in
//   encdec_sel_out      out  1    to core encdec_sel_in (registered key_dec_in)
//   enable_key_exp_out  out  1    to core enable_key_exp_in
//   user_key_valid_out  out  1    to core user_key_valid_in
//   user_key_out        out  128  to core user_key_in (registered)
//   valid_out           out  1    to core valid_in
//   data_out            out  128  to core data_in
//   key_exp_ready_in    in   1    from core key_exp_ready_out
//   core_valid_in       in   1    from core valid_out
//   core_result_in      in   128  from core result_out
//   busy_out            out  1    state != IDLE or in-flight != 0 or FIFO non-empty
//   err_out             out  1    sticky: core_valid_in seen with in-flight == 0
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, in-flight 0, state IDLE, err_out cleared.
//   FSM: IDLE, KEY_LOAD, KEY_WAIT, RUN, DRAIN.
//   - IDLE: key_ready_out=1. Key handshake captures key_in/key_dec_in and goes to KEY_LOAD.
//   - KEY_LOAD (1 cycle): sm4_enable_out=1, enable_key_exp_out=1, user_key_valid_out=1 -> KEY_WAIT.
//   - KEY_WAIT: sm4_enable_out=1, enable_key_exp_out=1; on key_exp_ready_in=1 -> RUN.
//   - RUN: sm4_enable_out=1, encdec_enable_out=1. key_ready_out=0.
//     blk_ready_out = (inflight + fifo_count < FIFO_DEPTH).
//     A block handshake drives valid_out=1 and data_out=blk_data_in (registered) next cycle.
//     key_valid_in=1 -> DRAIN; the block path is blocked from the same cycle.
//   - DRAIN: blk_ready_out=0; encdec_enable_out stays 1.
//     When inflight==0 (FIFO may still hold results): key_ready_out=1, and the key handshake -> KEY_LOAD.
//   - Result ordering: FIFO preserves core output order. Key change never discards buffered results.
//   Credit accounting:
//   - inflight +1 on block accept, -1 on core_valid_in. Both in the same cycle: unchanged.
//   - Push on core_valid_in; pop on res_valid_out & res_ready_in. Push+pop same cycle is legal, also when full.
//   - Invariant inflight + fifo_count <= FIFO_DEPTH. A push never finds the FIFO full.
//   - core_valid_in with inflight==0: result dropped, err_out set until reset.
//   Latency: block accept -> valid_out 1 cycle. core_valid_in -> res_valid_out 1 cycle (registered FIFO output).
//   Reset mid-operation: FSM, counters and FIFO cleared in the same edge. In-flight results are lost.
// STRUCTURE
//   sm4_pkg: ctrl_state_t enum, SM4_BLK_W=128, SM4_KEY_W=128.
//   Sub-module sm4_res_fifo: synchronous FIFO (FIFO_DEPTH x 128) with count output, pointer wrap on power of 2.
// TESTING
//   Encrypt: key/data 0123456789abcdeffedcba9876543210 -> result 681edf34d206965e86b3e94f536e4246.
//   Decrypt: key as above, key_dec_in=1, data 681edf34...6e4246 -> result 0123456789abcdeffedcba9876543210.
//   Backpressure: res_ready_in=0, 6 blocks offered -> exactly 4 accepted, blk_ready_out=0; release -> 4 out in order, then 2.
//   Rekey mid-stream: 3 blocks in flight, new key -> DRAIN; all 3 results under old key; KEY_LOAD only after inflight==0.
//   Full push+pop: FIFO full, res_ready_in=1 every cycle -> one result out per cycle, no loss, no duplicate.
//   Reset/err: reset_n=0 in RUN -> all outputs 0 next edge. Spurious core_valid_in with inflight 0 -> err_out=1, FIFO unchanged.

Source files
------------

// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared widths and controller state encoding for the SM4 host sequencer
package sm4_pkg;

    localparam int SM4_BLK_W = 128;
    localparam int SM4_KEY_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_LOAD,
        ST_KEY_WAIT,
        ST_RUN,
        ST_DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/sm4_host_ctrl_if.sv
// rtl/sm4_host_ctrl_if.sv - host-side key, block and result streams of the SM4 sequencer
interface sm4_host_ctrl_if
    import sm4_pkg::*;
();

    logic                 key_valid_in;
    logic [SM4_KEY_W-1:0] key_in;
    logic                 key_dec_in;
    logic                 key_ready_out;

    logic                 blk_valid_in;
    logic [SM4_BLK_W-1:0] blk_data_in;
    logic                 blk_ready_out;

    logic                 res_valid_out;
    logic [SM4_BLK_W-1:0] res_data_out;
    logic                 res_ready_in;

    // slave is the sequencer, master is whoever feeds keys/blocks and drains results
    modport slave (
        input  key_valid_in, key_in, key_dec_in,
        output key_ready_out,
        input  blk_valid_in, blk_data_in,
        output blk_ready_out,
        output res_valid_out, res_data_out,
        input  res_ready_in
    );

    modport master (
        output key_valid_in, key_in, key_dec_in,
        input  key_ready_out,
        output blk_valid_in, blk_data_in,
        input  blk_ready_out,
        input  res_valid_out, res_data_out,
        output res_ready_in
    );

endinterface

// File: rtl/sm4_res_fifo.sv
// rtl/sm4_res_fifo.sv - synchronous result FIFO with occupancy count
module sm4_res_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3,
    parameter int W     = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = cnt;

endmodule

// File: rtl/sm4_host_ctrl.sv
// rtl/sm4_host_ctrl.sv - sequences key load and block issue into the SM4 core, buffers its results
module sm4_host_ctrl
    import sm4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sm4_host_ctrl_if.slave       host,
    output logic                 sm4_enable_out,
    output logic                 encdec_enable_out,
    output logic                 encdec_sel_out,
    output logic                 enable_key_exp_out,
    output logic                 user_key_valid_out,
    output logic [SM4_KEY_W-1:0] user_key_out,
    output logic                 valid_out,
    output logic [SM4_BLK_W-1:0] data_out,
    input  logic                 key_exp_ready_in,
    input  logic                 core_valid_in,
    input  logic [SM4_BLK_W-1:0] core_result_in,
    output logic                 busy_out,
    output logic                 err_out
);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             key_rdy;
    logic             blk_rdy;
    logic             key_hs;
    logic             blk_hs;
    logic             core_ok;
    logic             core_spurious;

    assign credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
    assign key_hs        = host.key_valid_in && host.key_ready_out;
    assign blk_hs        = host.blk_valid_in && host.blk_ready_out;
    assign core_ok       = core_valid_in && (inflight != '0);
    assign core_spurious = core_valid_in && (inflight == '0);

    always_comb begin
        state_nxt          = state;
        key_rdy            = 1'b0;
        blk_rdy            = 1'b0;
        sm4_enable_out     = 1'b0;
        encdec_enable_out  = 1'b0;
        enable_key_exp_out = 1'b0;
        user_key_valid_out = 1'b0;
        case (state)
            ST_IDLE: begin
                key_rdy = 1'b1;
                if (host.key_valid_in) state_nxt = ST_KEY_LOAD;
            end
            ST_KEY_LOAD: begin
                sm4_enable_out     = 1'b1;
                enable_key_exp_out = 1'b1;
                user_key_valid_out = 1'b1;
                state_nxt          = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                sm4_enable_out     = 1'b1;
                enable_key_exp_out = 1'b1;
                if (key_exp_ready_in) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                sm4_enable_out    = 1'b1;
                encdec_enable_out = 1'b1;
                // a pending key request closes the block path immediately
                if (host.key_valid_in) state_nxt = ST_DRAIN;
                else blk_rdy = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
            end
            ST_DRAIN: begin
                sm4_enable_out    = 1'b1;
                encdec_enable_out = 1'b1;
                if (inflight == '0) begin
                    key_rdy = 1'b1;
                    if (host.key_valid_in) state_nxt = ST_KEY_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign host.key_ready_out = key_rdy && reset_n;
    assign host.blk_ready_out = blk_rdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            inflight       <= '0;
            err_out        <= 1'b0;
            user_key_out   <= '0;
            encdec_sel_out <= 1'b0;
            valid_out      <= 1'b0;
            data_out       <= '0;
        end else begin
            state     <= state_nxt;
            valid_out <= blk_hs;
            if (key_hs) begin
                user_key_out   <= host.key_in;
                encdec_sel_out <= host.key_dec_in;
            end
            if (blk_hs) data_out <= host.blk_data_in;
            case ({blk_hs, core_ok})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (core_spurious) err_out <= 1'b1;
        end
    end

    sm4_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W),
        .W     (SM4_BLK_W)
    ) u_res_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (core_ok),
        .push_data (core_result_in),
        .pop       (host.res_ready_in),
        .out_valid (host.res_valid_out),
        .out_data  (host.res_data_out),
        .count     (fifo_count)
    );

    assign busy_out = (state != ST_IDLE) || (inflight != '0) || (fifo_count != '0);

endmodule
